// File: rtl/cic_comb_decimator.sv
// Decimating comb section of a CIC decimator: keeps every DECIM-th strobed sample,
// runs STAGES valid-tagged comb stages, registers the top bits out. Macro: CIC_COMB_ROUND_EN.
module cic_comb_decimator #(
   parameter int unsigned DATA_WIDTH_INP = 16,
   parameter int unsigned DATA_WIDTH_OUT = 16,
   parameter int unsigned STAGES         = 3,
   parameter int unsigned DECIM          = 4,
   parameter int unsigned DIFF_DELAY     = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DATA_WIDTH_INP-1:0] inp_samp_data,
   input  logic                      inp_samp_str,
   output logic [DATA_WIDTH_OUT-1:0] out_samp_data,
   output logic                      out_samp_str
);

   localparam int unsigned CNT_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int unsigned FRAC_W = DATA_WIDTH_INP - DATA_WIDTH_OUT;
   localparam int unsigned RND_W  = DATA_WIDTH_OUT + 1;

   logic [CNT_W-1:0]          count;
   logic                      accept_c;
   logic [DATA_WIDTH_INP-1:0] stage_q [STAGES+1];
   logic [STAGES:0]           valid_q;
   logic [DATA_WIDTH_INP-1:0] dly_q   [STAGES][DIFF_DELAY];
   logic [DATA_WIDTH_OUT-1:0] out_next_c;
   logic                      unused_lsb_c;

   assign accept_c     = inp_samp_str && (count == '0);
   assign unused_lsb_c = ^stage_q[STAGES];

   // decimation counter: every strobe advances it, only count==0 is accepted
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (inp_samp_str) begin
         count <= (count == CNT_W'(DECIM - 1)) ? '0 : count + CNT_W'(1);
      end
   end

   // valid-tagged comb pipeline; delay lines advance only on valid samples
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         for (int k = 0; k <= int'(STAGES); k++) begin
            stage_q[k] <= '0;
         end
         for (int k = 0; k < int'(STAGES); k++) begin
            for (int j = 0; j < int'(DIFF_DELAY); j++) begin
               dly_q[k][j] <= '0;
            end
         end
      end else begin
         valid_q[0] <= accept_c;
         if (accept_c) begin
            stage_q[0] <= inp_samp_data;
         end
         for (int k = 1; k <= int'(STAGES); k++) begin
            valid_q[k] <= valid_q[k-1];
            if (valid_q[k-1]) begin
               stage_q[k]    <= stage_q[k-1] - dly_q[k-1][DIFF_DELAY-1];
               dly_q[k-1][0] <= stage_q[k-1];
               for (int j = 1; j < int'(DIFF_DELAY); j++) begin
                  dly_q[k-1][j] <= dly_q[k-1][j-1];
               end
            end
         end
      end
   end

   // output word selection: truncation, or round-half-up with positive saturation
   generate
`ifdef CIC_COMB_ROUND_EN
      if (FRAC_W > 0) begin : g_round
         localparam logic [DATA_WIDTH_OUT-1:0] MAX_POS =
            ~(DATA_WIDTH_OUT'(1) << (DATA_WIDTH_OUT - 1));
         logic [RND_W-1:0] rnd_c;
         always_comb begin
            // adding the half-LSB then truncating equals adding the first dropped bit
            rnd_c = {stage_q[STAGES][DATA_WIDTH_INP-1],
                     stage_q[STAGES][DATA_WIDTH_INP-1 -: DATA_WIDTH_OUT]}
                    + RND_W'(stage_q[STAGES][FRAC_W-1]);
            out_next_c = rnd_c[DATA_WIDTH_OUT-1:0];
            if (rnd_c[DATA_WIDTH_OUT] != rnd_c[DATA_WIDTH_OUT-1]) begin
               out_next_c = MAX_POS;
            end
         end
      end else begin : g_pass
         assign out_next_c = stage_q[STAGES][DATA_WIDTH_INP-1 -: DATA_WIDTH_OUT];
      end
`else
      if (RND_W > 0) begin : g_trunc
         assign out_next_c = stage_q[STAGES][DATA_WIDTH_INP-1 -: DATA_WIDTH_OUT];
      end
`endif
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         out_samp_data <= '0;
         out_samp_str  <= 1'b0;
      end else begin
         out_samp_str <= valid_q[STAGES];
         if (valid_q[STAGES]) begin
            out_samp_data <= out_next_c;
         end
      end
   end

endmodule

// File: tb/tb_cic_comb_decimator.sv
// Directed bench for cic_comb_decimator: five parameterisations driven from one
// vector table plus hand-written reset, mid-pipeline reset and decimation sequences.
module tb_cic_comb_decimator;

   logic        clk;
   logic        reset;
   logic [15:0] din  [5];
   logic        str  [5];
   logic [15:0] dout [4];
   logic [7:0]  dout4;
   logic        ostr [5];

   int n_cmp;
   int n_bad;

   // 0: N3 R4 M1   1: N3 R1 M1   2: N1 R1 M1   3: N1 R1 M2   4: N1 R1 M1, 16->8
   cic_comb_decimator #(.DATA_WIDTH_INP(16), .DATA_WIDTH_OUT(16), .STAGES(3),
                        .DECIM(4), .DIFF_DELAY(1)) u_dec (
      .clk(clk), .reset(reset), .inp_samp_data(din[0]), .inp_samp_str(str[0]),
      .out_samp_data(dout[0]), .out_samp_str(ostr[0]));
   cic_comb_decimator #(.DATA_WIDTH_INP(16), .DATA_WIDTH_OUT(16), .STAGES(3),
                        .DECIM(1), .DIFF_DELAY(1)) u_step (
      .clk(clk), .reset(reset), .inp_samp_data(din[1]), .inp_samp_str(str[1]),
      .out_samp_data(dout[1]), .out_samp_str(ostr[1]));
   cic_comb_decimator #(.DATA_WIDTH_INP(16), .DATA_WIDTH_OUT(16), .STAGES(1),
                        .DECIM(1), .DIFF_DELAY(1)) u_wrap (
      .clk(clk), .reset(reset), .inp_samp_data(din[2]), .inp_samp_str(str[2]),
      .out_samp_data(dout[2]), .out_samp_str(ostr[2]));
   cic_comb_decimator #(.DATA_WIDTH_INP(16), .DATA_WIDTH_OUT(16), .STAGES(1),
                        .DECIM(1), .DIFF_DELAY(2)) u_m2 (
      .clk(clk), .reset(reset), .inp_samp_data(din[3]), .inp_samp_str(str[3]),
      .out_samp_data(dout[3]), .out_samp_str(ostr[3]));
   cic_comb_decimator #(.DATA_WIDTH_INP(16), .DATA_WIDTH_OUT(8), .STAGES(1),
                        .DECIM(1), .DIFF_DELAY(1)) u_rnd (
      .clk(clk), .reset(reset), .inp_samp_data(din[4]), .inp_samp_str(str[4]),
      .out_samp_data(dout4), .out_samp_str(ostr[4]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int          sel;
      logic [15:0] data;
      logic [15:0] exp;
      int          lat;
      int          gap;
      string       name;
   } vec_t;

   vec_t vecs [13];

   function automatic logic [15:0] get_out(input int sel);
      if (sel == 4) return {8'h00, dout4};
      return dout[sel];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply_vec(input vec_t v);
      int lat;
      bit got;
      repeat (v.gap) @(negedge clk);
      @(negedge clk);
      din[v.sel] = v.data;
      str[v.sel] = 1'b1;
      @(posedge clk);
      #1 str[v.sel] = 1'b0;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 12) begin
         @(posedge clk);
         lat++;
         #1;
         if (ostr[v.sel]) got = 1'b1;
      end
      check({v.name, "_lat"}, 32'(lat), 32'(v.lat));
      check({v.name, "_data"}, {16'h0, get_out(v.sel)}, {16'h0, v.exp});
   endtask

   initial begin
      logic [15:0] exp_dec [4];
      logic [15:0] rnd_a;
      int          nstr;

      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         din[i] = 16'h0;
         str[i] = 1'b0;
      end

`ifdef CIC_COMB_ROUND_EN
      rnd_a = 16'h0002;
`else
      rnd_a = 16'h0001;
`endif
      //            sel data      exp       lat gap name
      vecs[0]  = '{1, 16'd5,    16'd5,    4, 0, "step0"};
      vecs[1]  = '{1, 16'd5,    16'hFFF6, 4, 0, "step1"};
      vecs[2]  = '{1, 16'd5,    16'd5,    4, 0, "step2"};
      vecs[3]  = '{1, 16'd5,    16'd0,    4, 0, "step3"};
      vecs[4]  = '{1, 16'd5,    16'd0,    4, 0, "step4"};
      vecs[5]  = '{2, 16'h7FFF, 16'h7FFF, 2, 0, "wrap0"};
      vecs[6]  = '{2, 16'h8000, 16'h0001, 2, 0, "wrap1"};
      vecs[7]  = '{3, 16'd1,    16'd1,    2, 3, "m2_0"};
      vecs[8]  = '{3, 16'd2,    16'd2,    2, 3, "m2_1"};
      vecs[9]  = '{3, 16'd4,    16'd3,    2, 3, "m2_2"};
      vecs[10] = '{3, 16'd8,    16'd6,    2, 3, "m2_3"};
      vecs[11] = '{4, 16'h0180, rnd_a,    2, 0, "rnd_0180"};
      vecs[12] = '{4, 16'h817F, 16'h007F, 2, 0, "rnd_7fff"};

      // reset held with strobes toggling: outputs stay cleared
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         for (int i = 0; i < 5; i++) begin
            str[i] = c[0];
            din[i] = 16'(16'h1111 * (c + 1));
         end
         @(posedge clk);
         #1;
         for (int i = 0; i < 5; i++) begin
            check("rst_str", {31'h0, ostr[i]}, 32'h0);
            check("rst_data", {16'h0, get_out(i)}, 32'h0);
         end
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) str[i] = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 5; i++) check("idle_str", {31'h0, ostr[i]}, 32'h0);
      end

      // reset while a sample is in flight discards it
      @(negedge clk);
      din[0] = 16'h1234;
      str[0] = 1'b1;
      @(posedge clk);
      #1 str[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      nstr = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         if (ostr[0]) nstr++;
      end
      check("midrst_strobes", 32'(nstr), 32'h0);
      check("midrst_data", {16'h0, get_out(0)}, 32'h0);

      // back-to-back strobes, R=4: accepted 1,5,9,13 -> third difference 1,2,-3,0
      exp_dec[0] = 16'd1;
      exp_dec[1] = 16'd2;
      exp_dec[2] = 16'hFFFD;
      exp_dec[3] = 16'd0;
      nstr = 0;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         str[0] = (k < 16);
         din[0] = 16'(k + 1);
         @(posedge clk);
         #1;
         if (ostr[0]) begin
            if (nstr < 4) begin
               check("dec_pos", 32'(k), 32'(4 * (nstr + 1)));
               check("dec_data", {16'h0, get_out(0)}, {16'h0, exp_dec[nstr]});
            end
            nstr++;
         end
      end
      str[0] = 1'b0;
      check("dec_count", 32'(nstr), 32'd4);

      for (int i = 0; i < 13; i++) begin
         apply_vec(vecs[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
